// File: rtl/noc_router_pkg.sv
// Shared router definitions: default flit/buffer sizing and the virtual-channel id type.
package noc_router_pkg;

   localparam int unsigned FLIT_W_DEF = 32;
   localparam int unsigned DEPTH_DEF  = 4;

   typedef enum logic {
      VC0 = 1'b0,
      VC1 = 1'b1
   } vc_id_t;

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel circular FIFO with combinational head and occupancy count.
module vc_fifo #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vc_input_buffer.sv
// Two-VC router input buffer: demuxes arriving flits into per-VC FIFOs,
// presents the selected VC's head downstream and returns one credit per pop.
module vc_input_buffer
   import noc_router_pkg::*;
#(
   parameter int unsigned FLIT_W = FLIT_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_vc,
   input  logic [FLIT_W-1:0] in_flit,
   input  logic              selected_vc,
   input  logic              out_ready,
   output logic              vc0_valid,
   output logic              vc1_valid,
   output logic [FLIT_W-1:0] out_flit,
   output logic [1:0]        credit_out,
   output logic              overflow
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   vc_id_t            wr_vc;
   vc_id_t            rd_vc;
   logic [1:0]        push;
   logic [1:0]        pop_done;
   logic [1:0]        drop;
   logic [1:0]        full;
   logic [1:0]        empty;
   logic [FLIT_W-1:0] head  [2];
   logic [CNT_W-1:0]  count [2];

   assign wr_vc = vc_id_t'(in_vc);
   assign rd_vc = vc_id_t'(selected_vc);

   for (genvar v = 0; v < 2; v++) begin : g_vc
      logic wr_hit;
      assign wr_hit      = in_valid && (wr_vc == vc_id_t'(1'(v)));
      assign pop_done[v] = out_ready && (rd_vc == vc_id_t'(1'(v))) && !empty[v];
      assign push[v]     = wr_hit && (!full[v] || pop_done[v]);
      assign drop[v]     = wr_hit && full[v] && !pop_done[v];

      vc_fifo #(
         .W     (FLIT_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[v]),
         .pop   (pop_done[v]),
         .din   (in_flit),
         .head  (head[v]),
         .count (count[v]),
         .full  (full[v]),
         .empty (empty[v])
      );
   end

   assign vc0_valid = (count[0] != '0);
   assign vc1_valid = (count[1] != '0);
   assign out_flit  = (rd_vc == VC1) ? head[1] : head[0];

   // Credits mirror completed pops one cycle later; overflow latches any dropped write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credit_out <= '0;
         overflow   <= 1'b0;
      end else begin
         credit_out <= pop_done;
         overflow   <= overflow | (|drop);
      end
   end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Randomized + directed bench for vc_input_buffer against a queue-based reference model.
module tb_vc_input_buffer;

   localparam int unsigned FLIT_W = 32;
   localparam int unsigned DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_vc;
   logic [FLIT_W-1:0] in_flit;
   logic              selected_vc;
   logic              out_ready;
   logic              vc0_valid;
   logic              vc1_valid;
   logic [FLIT_W-1:0] out_flit;
   logic [1:0]        credit_out;
   logic              overflow;

   int n_tests  = 0;
   int n_failed = 0;
   int cred0_cnt;

   logic [FLIT_W-1:0] q0[$];
   logic [FLIT_W-1:0] q1[$];
   logic [1:0]        exp_credit;
   logic              exp_ovf;

   vc_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_vc       (in_vc),
      .in_flit     (in_flit),
      .selected_vc (selected_vc),
      .out_ready   (out_ready),
      .vc0_valid   (vc0_valid),
      .vc1_valid   (vc1_valid),
      .out_flit    (out_flit),
      .credit_out  (credit_out),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_failed++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive at negedge, compare against model, then advance model to the next edge.
   task automatic cycle(input logic iv, input logic ivc, input logic [31:0] fl,
                        input logic sel, input logic rdy);
      logic popd;
      @(negedge clk);
      in_valid    = iv;
      in_vc       = ivc;
      in_flit     = fl;
      selected_vc = sel;
      out_ready   = rdy;
      #1;
      check("vc0_valid", 32'(vc0_valid), 32'(q0.size() != 0));
      check("vc1_valid", 32'(vc1_valid), 32'(q1.size() != 0));
      check("credit_out", 32'(credit_out), 32'(exp_credit));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      if (credit_out[0]) cred0_cnt++;
      if (!sel && q0.size() != 0) check("out_flit_vc0", out_flit, q0[0]);
      if (sel && q1.size() != 0)  check("out_flit_vc1", out_flit, q1[0]);

      popd = 1'b0;
      if (rdy) begin
         if (!sel && q0.size() != 0) begin void'(q0.pop_front()); popd = 1'b1; end
         if (sel && q1.size() != 0)  begin void'(q1.pop_front()); popd = 1'b1; end
      end
      exp_credit = popd ? (sel ? 2'b10 : 2'b01) : 2'b00;
      if (iv) begin
         if (!ivc) begin
            if (q0.size() < DEPTH) q0.push_back(fl); else exp_ovf = 1'b1;
         end else begin
            if (q1.size() < DEPTH) q1.push_back(fl); else exp_ovf = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("rst_vc0_valid", 32'(vc0_valid), 32'd0);
      check("rst_vc1_valid", 32'(vc1_valid), 32'd0);
      check("rst_credit", 32'(credit_out), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      q0.delete();
      q1.delete();
      exp_credit = 2'b00;
      exp_ovf    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_vc = 1'b0; in_flit = '0;
      selected_vc = 1'b0; out_ready = 1'b0;
      exp_credit = 2'b00; exp_ovf = 1'b0; cred0_cnt = 0;
      repeat (2) @(negedge clk);
      do_reset();

      // Single push to VC0 becomes visible next cycle.
      cycle(1, 0, 32'hA0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0);

      // Fill VC1, overflow on the fifth write, drain in order.
      for (int i = 1; i <= 5; i++) cycle(1, 1, 32'(i), 1, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 0);

      // Full VC1 accepts a write alongside a pop.
      for (int i = 1; i <= 4; i++) cycle(1, 1, 32'h10 + 32'(i), 1, 0);
      cycle(1, 1, 32'h9, 1, 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 1);

      // Pop VC0 while pushing VC1.
      cycle(1, 0, 32'hB0, 0, 0);
      cycle(1, 1, 32'hC0, 0, 1);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 0);

      // Ten push/pop pairs on VC0 wrap the pointers.
      cred0_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1, 0, 32'h100 + 32'(i), 0, 0);
         cycle(0, 0, 0, 0, 1);
      end
      cycle(0, 0, 0, 0, 0);
      check("credit0_pulses", 32'(cred0_cnt), 32'd10);

      // Reset with three flits in VC0 and overflow set.
      for (int i = 0; i < 5; i++) cycle(1, 1, 32'h200 + 32'(i), 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 32'h300 + 32'(i), 0, 0);
      do_reset();
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
               1'($urandom), 1'($urandom_range(0, 2) == 0));
         if (i == 200) do_reset();
      end
      for (int i = 0; i < 2 * DEPTH; i++) cycle(0, 0, 0, 1'(i), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
